uno_coef_seq: RTL and testbench

UNO_COEF_SEQ -- requirements
Module: uno_coef_seq

---
 rtl/uno_coef_seq.sv | 164 ++++++++++++++++
 tb/tb_uno_coef_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uno_coef_seq.sv
// Coefficient sequencer for the unary (div/exp/log) PE chain.
// Each request streams one bank of polynomial coefficients, highest index first.
module uno_coef_seq #(
    parameter int MUL_BW = 16,
    parameter int TERMS  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_op,
    input  logic signed [MUL_BW-1:0]    in_x,
    input  logic [$clog2(TERMS)-1:0]    in_nterms,
    input  logic                        cfg_we,
    input  logic [1:0]                  cfg_op,
    input  logic [$clog2(TERMS)-1:0]    cfg_idx,
    input  logic signed [MUL_BW-1:0]    cfg_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [1:0]                  gemm_uno_o,
    output logic signed [MUL_BW-1:0]    x_o,
    output logic signed [MUL_BW-1:0]    wc_o,
    output logic                        last_o,
    output logic                        done,
    output logic                        err
);
    localparam int IW = $clog2(TERMS);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    state_e                   state_q;
    logic [1:0]               op_q;
    logic signed [MUL_BW-1:0] x_q;
    logic signed [MUL_BW-1:0] wc_q;
    logic [IW-1:0]            k_q;
    logic                     valid_q;
    logic                     last_q;
    logic                     done_q;
    logic                     err_q;
    logic signed [MUL_BW-1:0] coef_q [0:2][0:TERMS-1];

    logic                     cfg_ok_s;
    logic                     cfg_err_s;
    logic                     accept_s;
    logic                     illegal_s;
    logic                     beat_hs_s;
    logic [1:0]               nxt_op_s;
    logic [IW-1:0]            nxt_k_s;
    logic signed [MUL_BW-1:0] rd_wc_s;
    logic signed [MUL_BW-1:0] nxt_wc_s;

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = valid_q;
    assign gemm_uno_o = op_q;
    assign x_o        = x_q;
    assign wc_o       = wc_q;
    assign last_o     = last_q;
    assign done       = done_q;
    assign err        = err_q;

    // Classify this cycle's cfg write and request; look up the next beat's coefficient
    always_comb begin
        cfg_ok_s  = 1'b0;
        cfg_err_s = 1'b0;
        if (!cfg_we) begin
            cfg_ok_s = 1'b0;
        end else if (cfg_op == 2'b00) begin
            cfg_err_s = 1'b1;
        end else if ((state_q == S_RUN) && (cfg_op == op_q)) begin
            cfg_err_s = 1'b1;
        end else begin
            cfg_ok_s = 1'b1;
        end

        accept_s  = (state_q == S_IDLE) && in_valid && (in_op != 2'b00);
        illegal_s = (state_q == S_IDLE) && in_valid && (in_op == 2'b00);
        beat_hs_s = (state_q == S_RUN) && out_ready;

        // in_nterms==0 wraps to TERMS-1, which is exactly the TERMS-term start index
        if (accept_s) begin
            nxt_op_s = in_op;
            nxt_k_s  = in_nterms - IW'(1);
        end else begin
            nxt_op_s = op_q;
            nxt_k_s  = k_q - IW'(1);
        end

        case (nxt_op_s)
            2'b01:   rd_wc_s = coef_q[0][nxt_k_s];
            2'b10:   rd_wc_s = coef_q[1][nxt_k_s];
            2'b11:   rd_wc_s = coef_q[2][nxt_k_s];
            default: rd_wc_s = {MUL_BW{1'b0}};
        endcase

        // A write landing on the acceptance edge must be visible to the first beat
        nxt_wc_s = (cfg_ok_s && (cfg_op == nxt_op_s) && (cfg_idx == nxt_k_s)) ? cfg_data : rd_wc_s;
    end

    // Coefficient banks, one per unary op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                for (int i = 0; i < TERMS; i++) begin
                    coef_q[b][i] <= {MUL_BW{1'b0}};
                end
            end
        end else if (cfg_ok_s) begin
            case (cfg_op)
                2'b01:   coef_q[0][cfg_idx] <= cfg_data;
                2'b10:   coef_q[1][cfg_idx] <= cfg_data;
                2'b11:   coef_q[2][cfg_idx] <= cfg_data;
                default: ;
            endcase
        end
    end

    // Sequencer FSM with registered beat outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            x_q     <= {MUL_BW{1'b0}};
            wc_q    <= {MUL_BW{1'b0}};
            k_q     <= {IW{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= illegal_s | cfg_err_s;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        state_q <= S_RUN;
                        op_q    <= in_op;
                        x_q     <= in_x;
                        k_q     <= nxt_k_s;
                        wc_q    <= nxt_wc_s;
                        valid_q <= 1'b1;
                        last_q  <= (nxt_k_s == {IW{1'b0}});
                    end
                end
                S_RUN: begin
                    if (beat_hs_s && (k_q == {IW{1'b0}})) begin
                        state_q <= S_IDLE;
                        op_q    <= 2'b00;
                        x_q     <= {MUL_BW{1'b0}};
                        wc_q    <= {MUL_BW{1'b0}};
                        k_q     <= {IW{1'b0}};
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (beat_hs_s) begin
                        k_q    <= nxt_k_s;
                        wc_q   <= nxt_wc_s;
                        last_q <= (nxt_k_s == {IW{1'b0}});
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uno_coef_seq.sv
// Directed self-checking bench for uno_coef_seq (MUL_BW=16, TERMS=8).
`timescale 1ns/1ps
module tb_uno_coef_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_x;
    logic [2:0]  in_nterms;
    logic        cfg_we;
    logic [1:0]  cfg_op;
    logic [2:0]  cfg_idx;
    logic [15:0] cfg_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  gemm_uno_o;
    logic [15:0] x_o;
    logic [15:0] wc_o;
    logic        last_o;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [15:0] coef_m [4][8];

    uno_coef_seq #(.MUL_BW(16), .TERMS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_x(in_x),
        .in_nterms(in_nterms),
        .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready), .gemm_uno_o(gemm_uno_o),
        .x_o(x_o), .wc_o(wc_o), .last_o(last_o), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int o = 0; o < 4; o++)
            for (int i = 0; i < 8; i++)
                coef_m[o][i] = 16'h0000;
    endtask

    task automatic cfg_write(input string tag, input logic [1:0] op, input logic [2:0] idx,
                             input logic [15:0] data, input logic exp_err);
        cfg_we = 1'b1; cfg_op = op; cfg_idx = idx; cfg_data = data;
        step();
        cfg_we = 1'b0;
        check_eq(tag, err, exp_err);
        if (!exp_err) coef_m[op][idx] = data;
    endtask

    task automatic idle_checks(input string tag);
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_ovalid"}, out_valid, 1'b0);
        check_eq({tag, "_ready"}, in_ready, 1'b1);
        check_eq({tag, "_wc0"}, wc_o, 16'h0000);
        check_eq({tag, "_x0"}, x_o, 16'h0000);
        check_eq({tag, "_op0"}, gemm_uno_o, 2'b00);
        check_eq({tag, "_last0"}, last_o, 1'b0);
        step();
        check_eq({tag, "_donepulse"}, done, 1'b0);
    endtask

    // Issue a request and check every beat; optionally stall stall_len cycles at beat stall_beat
    task automatic run_seq(input string tag, input logic [1:0] op, input logic [15:0] x,
                           input logic [2:0] nt, input int stall_beat, input int stall_len);
        int n;
        int beat;
        int stalls;
        int cyc;
        n = (nt == 3'd0) ? 8 : int'(nt);
        in_valid = 1'b1; in_op = op; in_x = x; in_nterms = nt; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        beat = 0; stalls = 0; cyc = 0;
        while (beat < n && cyc < 64) begin
            check_eq($sformatf("%s_valid%0d", tag, beat), out_valid, 1'b1);
            check_eq($sformatf("%s_wc%0d", tag, beat), wc_o, coef_m[op][n-1-beat]);
            check_eq($sformatf("%s_x%0d", tag, beat), x_o, x);
            check_eq($sformatf("%s_op%0d", tag, beat), gemm_uno_o, op);
            check_eq($sformatf("%s_last%0d", tag, beat), last_o, (beat == n-1));
            check_eq($sformatf("%s_busy%0d", tag, beat), in_ready, 1'b0);
            if (beat == stall_beat && stalls < stall_len) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
                beat++;
            end
            step();
            cyc++;
        end
        check_eq({tag, "_timeout"}, cyc, n + ((stall_beat >= 0) ? stall_len : 0));
        out_ready = 1'b1;
        idle_checks(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_x = 16'h0000; in_nterms = 3'd0;
        cfg_we = 1'b0; cfg_op = 2'b00; cfg_idx = 3'd0; cfg_data = 16'h0000; out_ready = 1'b0;
        clear_model();
        #1;
        check_eq("rst_ovalid", out_valid, 1'b0);
        check_eq("rst_ready", in_ready, 1'b1);
        check_eq("rst_wc", wc_o, 16'h0000);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        step(); step();
        rst_n = 1'b1;
        step();

        // exp bank 1,2,3,4 then Horner-order streaming
        cfg_write("cfg_e0", 2'b10, 3'd0, 16'd1, 1'b0);
        cfg_write("cfg_e1", 2'b10, 3'd1, 16'd2, 1'b0);
        cfg_write("cfg_e2", 2'b10, 3'd2, 16'd3, 1'b0);
        cfg_write("cfg_e3", 2'b10, 3'd3, 16'd4, 1'b0);
        run_seq("r38", 2'b10, 16'h0400, 3'd4, -1, 0);
        run_seq("r39", 2'b10, 16'h0400, 3'd4, 1, 3);

        // illegal gemm request
        in_valid = 1'b1; in_op = 2'b00; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("r40_err", err, 1'b1);
        check_eq("r40_ovalid", out_valid, 1'b0);
        check_eq("r40_ready", in_ready, 1'b1);
        step();
        check_eq("r40_errpulse", err, 1'b0);
        check_eq("r40_ovalid2", out_valid, 1'b0);
        cfg_write("r33_op00", 2'b00, 3'd0, 16'h0005, 1'b1);

        // cfg writes while an exp run is stalled on its first beat
        in_valid = 1'b1; in_op = 2'b10; in_x = 16'h0011; in_nterms = 3'd4; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check_eq("r41_wc_first", wc_o, 16'd4);
        cfg_write("r41_blk_err", 2'b10, 3'd3, 16'h7777, 1'b1);
        check_eq("r41_blk_hold", wc_o, 16'd4);
        cfg_write("r41_div_ok", 2'b01, 3'd2, 16'h0123, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("r41_run_wc%0d", i), wc_o, 16'(4 - i));
            step();
        end
        idle_checks("r41_end");
        run_seq("r41e", 2'b10, 16'h0033, 3'd4, -1, 0);
        run_seq("r41d", 2'b01, 16'h0044, 3'd3, -1, 0);

        // write and request on the same edge
        cfg_we = 1'b1; cfg_op = 2'b11; cfg_idx = 3'd1; cfg_data = 16'h0abc;
        in_valid = 1'b1; in_op = 2'b11; in_x = 16'h0042; in_nterms = 3'd2; out_ready = 1'b1;
        step();
        cfg_we = 1'b0; in_valid = 1'b0;
        coef_m[3][1] = 16'h0abc;
        check_eq("r34_wc1", wc_o, 16'h0abc);
        check_eq("r34_err", err, 1'b0);
        check_eq("r34_last1", last_o, 1'b0);
        step();
        check_eq("r34_wc0", wc_o, 16'h0000);
        check_eq("r34_last0", last_o, 1'b1);
        step();
        idle_checks("r34_end");

        // nterms=0 -> full TERMS beats
        cfg_write("cfg_e5", 2'b10, 3'd5, 16'h0050, 1'b0);
        cfg_write("cfg_e7", 2'b10, 3'd7, 16'h0070, 1'b0);
        run_seq("r42", 2'b10, 16'h0777, 3'd0, -1, 0);

        // async reset mid-run
        in_valid = 1'b1; in_op = 2'b10; in_x = 16'h0555; in_nterms = 3'd4; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_eq("r43_pre_wc", wc_o, 16'd3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("r43_ovalid", out_valid, 1'b0);
        check_eq("r43_wc", wc_o, 16'h0000);
        check_eq("r43_x", x_o, 16'h0000);
        check_eq("r43_op", gemm_uno_o, 2'b00);
        check_eq("r43_last", last_o, 1'b0);
        check_eq("r43_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        check_eq("r43_nodone", done, 1'b0);
        step();
        check_eq("r43_nodone2", done, 1'b0);
        check_eq("r43_idle", out_valid, 1'b0);
        clear_model();
        run_seq("r43", 2'b11, 16'h0222, 3'd4, -1, 0);
        run_seq("r43e", 2'b10, 16'h0223, 3'd4, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
